mem_subword_unit: RTL

Parametrised sub-word load/store unit for the MEM stage. It sits between the pipeline's memory-stage request and a word-wide data memory with no byte enables. Loads extract and zero- or sign-extend a byte, halfword or full word. Sub-word stores are done as an internal read-modify-write through a small handshake FSM, and misaligned accesses are flagged without touching memory.

---
 rtl/mem_subword_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_subword_unit.sv
// Sub-word load/store unit for the MEM stage: byte/half/word loads with
// zero/sign extension, sub-word stores via read-modify-write on a word-wide
// memory without byte enables, and misalignment detection.
module mem_subword_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned OFF_W     = $clog2(DATA_W / 8);
  localparam logic [1:0]  SIZE_WORD = 2'(OFF_W);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state_q, state_d;

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] align_mask;

  logic [1:0]        size_q;
  logic              signed_q;
  logic              we_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] wdata_q;

  int unsigned       lane_w;
  int unsigned       lane_lsb;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_data;
  logic              lane_msb;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  // Request acceptance and error classification on the raw request fields
  always_comb begin
    accept     = req_valid && req_ready;
    align_mask = (ADDR_W'(1) << req_size) - ADDR_W'(1);
    req_err    = (req_size > SIZE_WORD) || ((req_addr & align_mask) != '0);
  end

  // Lane position, load extraction/extension and store merge from captured fields
  always_comb begin
    lane_w    = 32'(8) << size_q;
    lane_lsb  = BIG_ENDIAN ? (DATA_W - (32'(off_q) * 32'd8) - lane_w)
                           : (32'(off_q) * 32'd8);
    lane_mask = '0;
    lane_msb  = 1'b0;
    load_ext  = '0;
    lane_data = mem_rdata >> lane_lsb;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      lane_mask[i] = (i < lane_w);
      if (i == lane_w - 32'd1) lane_msb = lane_data[i];
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < lane_w) ? lane_data[i] : (signed_q & lane_msb);
    end
    merged = (mem_rdata & ~(lane_mask << lane_lsb)) |
             ((wdata_q & lane_mask) << lane_lsb);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                    state_d = RESP;
          else if (!req_we)               state_d = RD;
          else if (req_size == SIZE_WORD) state_d = WR;
          else                            state_d = RD;
        end
      end
      RD:      if (mem_ack) state_d = we_q ? WR : RESP;
      WR:      if (mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Registered handshake, strobe and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      req_ready  <= (state_d == IDLE);
      mem_rd     <= (state_d == RD);
      mem_wr     <= (state_d == WR);
      resp_valid <= (state_d == RESP);
      // Only an error goes straight from IDLE to RESP
      resp_err   <= (state_q == IDLE) && (state_d == RESP);
      // Only a load goes from RD to RESP
      resp_rdata <= ((state_q == RD) && (state_d == RESP)) ? load_ext : '0;
    end
  end

  // Request capture, memory address and write word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q    <= '0;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        size_q   <= req_size;
        signed_q <= req_signed;
        we_q     <= req_we;
        off_q    <= req_addr[OFF_W-1:0];
        wdata_q  <= req_wdata;
        if (!req_err) mem_addr <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      end
      if ((state_q == IDLE) && (state_d == WR))    mem_wdata <= req_wdata;
      else if ((state_q == RD) && (state_d == WR)) mem_wdata <= merged;
    end
  end

endmodule
